// File: rtl/fetch_pkg.sv
// Shared geometry, queue entry type and lane-mask helper for the fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN_CFG        = 32;
  localparam int unsigned FETCH_WIDTH_CFG = 2;
  localparam int unsigned GROUP_BYTES     = 4 * FETCH_WIDTH_CFG;
  localparam int unsigned OFFSET_BITS     = $clog2(GROUP_BYTES);

  typedef struct packed {
    logic [XLEN_CFG-1:0]          pc;
    logic [32*FETCH_WIDTH_CFG-1:0] instr;
    logic [FETCH_WIDTH_CFG-1:0]   mask;
  } fetch_entry_t;

  // Lanes below the entry lane of a redirect target are not part of the new path.
  function automatic logic [FETCH_WIDTH_CFG-1:0] lane_mask(input int unsigned offset);
    logic [FETCH_WIDTH_CFG-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH_CFG; i++) begin
      m[i] = (i >= offset);
    end
    return m;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch groups with flush; head is presented combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  fetch_entry_t                push_data,
  output fetch_entry_t                head,
  output logic                        head_valid,
  output logic [$clog2(QDEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_entry_t   mem [QDEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !(rst || flush)) begin
      mem[wptr_q] <= push_data;
    end
  end

  assign head       = mem[rptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

  // Credit accounting upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (rst || flush)
                   !(push && !pop && count_q == CW'(QDEPTH)))
    else $error("push into full fetch queue");

endmodule

// File: rtl/fetch_group_queue.sv
// Fetch PC generator issuing aligned group reads, with prioritised redirects and
// credit-limited buffering of returned groups toward decode.
module fetch_group_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_CFG,
  parameter int unsigned     FETCH_WIDTH = FETCH_WIDTH_CFG,
  parameter int unsigned     QDEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jal,
  input  logic [XLEN-1:0]          jal_addr,
  input  logic                     jalr_jcond,
  input  logic [XLEN-1:0]          jalr_jcond_addr,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [32*FETCH_WIDTH-1:0] imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [32*FETCH_WIDTH-1:0] out_instr,
  output logic [FETCH_WIDTH-1:0]   out_mask,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0]        pc_q, tag_pc_q;
  logic [FETCH_WIDTH-1:0] start_mask_q, tag_mask_q;
  logic                   inflight_q;

  logic                   redirect, issue, push, pop, head_valid;
  logic [XLEN-1:0]        target, base, lane_off;
  logic [CW-1:0]          count;
  fetch_entry_t           push_entry, head;

  always_comb begin
    redirect = jal || jalr_jcond;
    target   = (jalr_jcond ? jalr_jcond_addr : jal_addr) & ~XLEN'(3);
    lane_off = (target >> 2) & XLEN'(FETCH_WIDTH - 1);
    base     = pc_q & ~XLEN'(GROUP_BYTES - 1);
    // The in-flight response already owns a queue slot.
    issue    = !rst && (32'(count) + 32'(inflight_q) < QDEPTH) && !redirect;
    push     = inflight_q && !redirect && !rst;
    pop      = out_valid && out_ready;
  end

  assign imem_req  = issue;
  assign imem_addr = base;
  assign busy      = !rst && !issue && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      start_mask_q <= '1;
    end else if (redirect) begin
      pc_q         <= target;
      inflight_q   <= 1'b0;
      start_mask_q <= lane_mask(32'(lane_off));
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q         <= base + XLEN'(GROUP_BYTES);
        start_mask_q <= '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_pc_q   <= base;
      tag_mask_q <= start_mask_q;
    end
  end

  assign push_entry = '{pc: tag_pc_q, instr: imem_rdata, mask: tag_mask_q};

  fetch_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_entry),
    .head      (head),
    .head_valid(head_valid),
    .count     (count)
  );

  // Wrong-path heads must never complete a handshake during a redirect.
  assign out_valid = head_valid && !redirect && !rst;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_mask  = head.mask;

endmodule
